// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter among N
// byte-stream requesters. A winner holds the transmitter for a whole frame
// (until its byte flagged last has gone out); each byte is paced against
// is_transmitting, with a stall watchdog when the UART never goes busy.
//
// Optional feature: define UART_TX_SCHED_CRLF_EN to append 8'h0d, 8'h0a to
// every frame (no req_ack, counted in bytes_sent, lock held until LF is done).
//
// Ports:
//   sys_clk, rst_n         clock, asynchronous active-low reset
//   req_valid/data/last    per-requester byte offer (data of i at [8i+7:8i])
//   req_ack                one-cycle pulse: requester's byte was latched
//   transmit, tx_byte      launch pulse and byte to the UART
//   is_transmitting        UART busy flag
//   active, owner          frame in progress, one-hot current/last owner
//   bytes_sent             launched byte count (wraps)
//   err_stall              sticky: a launch was never acknowledged by busy
module uart_tx_sched #(
    parameter int unsigned N            = 4,
    parameter int unsigned STALL_CYCLES = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_valid,
    input  logic [8*N-1:0]   req_data,
    input  logic [N-1:0]     req_last,
    output logic [N-1:0]     req_ack,
    output logic             transmit,
    output logic [7:0]       tx_byte,
    input  logic             is_transmitting,
    output logic             active,
    output logic [N-1:0]     owner,
    output logic [CNT_W-1:0] bytes_sent,
    output logic             err_stall
);

    localparam int unsigned PTR_W   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
`ifdef UART_TX_SCHED_CRLF_EN
        HOLD,
        CR,
        LF
`else
        HOLD
`endif
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   own_idx;
    logic               last_q;
    logic [STALL_W-1:0] stall_cnt;
`ifdef UART_TX_SCHED_CRLF_EN
    logic [1:0]         tail;       // 0: data byte, 1: CR sent, 2: LF sent
`endif

    logic               win_found_c;
    logic [PTR_W-1:0]   win_idx_c;
    logic [PTR_W-1:0]   sel_idx_c;
    logic [N-1:0]       onehot_c;
    logic [7:0]         sel_data_c;
    logic               sel_last_c;
    logic               launch_c;
    logic               stall_hit_c;
    logic               byte_done_c;
    logic [PTR_W-1:0]   nxt_ptr_c;

    // First valid requester scanning upward from ptr, modulo N.
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (req_valid[PTR_W'((int'(ptr) + k) % int'(N))]) begin
                win_found_c = 1'b1;
                win_idx_c   = PTR_W'((int'(ptr) + k) % int'(N));
            end
        end
    end

    // Launch source: arbitration winner from IDLE, locked owner from HOLD.
    always_comb begin
        sel_idx_c   = (state == HOLD) ? own_idx : win_idx_c;
        onehot_c    = N'(1) << sel_idx_c;
        sel_data_c  = req_data[{sel_idx_c, 3'b000} +: 8];
        sel_last_c  = req_last[sel_idx_c];
        launch_c    = ((state == IDLE) && !is_transmitting && win_found_c) ||
                      ((state == HOLD) && req_valid[own_idx]);
        stall_hit_c = (stall_cnt >= STALL_W'(STALL_CYCLES - 1));
        // A byte is finished when busy drops, or when the watchdog gives up on it.
        byte_done_c = !is_transmitting &&
                      ((state == WAIT_DONE) || ((state == WAIT_BUSY) && stall_hit_c));
        nxt_ptr_c   = (own_idx == PTR_W'(N - 1)) ? '0 : own_idx + PTR_W'(1);
    end

    // Scheduler FSM with registered outputs; transmit/req_ack default low each cycle.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            own_idx    <= '0;
            owner      <= '0;
            active     <= 1'b0;
            transmit   <= 1'b0;
            req_ack    <= '0;
            tx_byte    <= 8'h00;
            last_q     <= 1'b0;
            bytes_sent <= '0;
            err_stall  <= 1'b0;
            stall_cnt  <= '0;
`ifdef UART_TX_SCHED_CRLF_EN
            tail       <= 2'd0;
`endif
        end else begin
            transmit <= 1'b0;
            req_ack  <= '0;
            case (state)
                IDLE, HOLD: begin
                    // Data is latched here so the pulse cycle (LAUNCH) already carries it.
                    if (launch_c) begin
                        own_idx    <= sel_idx_c;
                        owner      <= onehot_c;
                        active     <= 1'b1;
                        transmit   <= 1'b1;
                        req_ack    <= onehot_c;
                        tx_byte    <= sel_data_c;
                        last_q     <= sel_last_c;
                        bytes_sent <= bytes_sent + CNT_W'(1);
`ifdef UART_TX_SCHED_CRLF_EN
                        tail       <= 2'd0;
`endif
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    stall_cnt <= STALL_W'(1);
                    state     <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (is_transmitting) begin
                        state <= WAIT_DONE;
                    end else if (stall_hit_c) begin
                        err_stall <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + STALL_W'(1);
                    end
                end
                WAIT_DONE: begin
                end
`ifdef UART_TX_SCHED_CRLF_EN
                CR: begin
                    transmit   <= 1'b1;
                    tx_byte    <= 8'h0d;
                    bytes_sent <= bytes_sent + CNT_W'(1);
                    tail       <= 2'd1;
                    state      <= LAUNCH;
                end
                LF: begin
                    transmit   <= 1'b1;
                    tx_byte    <= 8'h0a;
                    bytes_sent <= bytes_sent + CNT_W'(1);
                    tail       <= 2'd2;
                    state      <= LAUNCH;
                end
`endif
                default: state <= IDLE;
            endcase

            // Byte completion: continue the frame, start the trailer, or release the lock.
            if (byte_done_c) begin
`ifdef UART_TX_SCHED_CRLF_EN
                if (tail == 2'd2) begin
                    active <= 1'b0;
                    ptr    <= nxt_ptr_c;
                    state  <= IDLE;
                end else if (tail == 2'd1) begin
                    state <= LF;
                end else if (last_q) begin
                    state <= CR;
                end else begin
                    state <= HOLD;
                end
`else
                if (last_q) begin
                    active <= 1'b0;
                    ptr    <= nxt_ptr_c;
                    state  <= IDLE;
                end else begin
                    state <= HOLD;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: per-requester byte queues, a UART
// busy model, and a frame-level reference that predicts owner, byte order,
// acks and bytes_sent from the round-robin/frame-lock rules.
module tb_uart_tx_sched;

    localparam int N     = 4;
    localparam int STALL = 16;
    localparam int CNT_W = 16;
    localparam int QD    = 256;
`ifdef UART_TX_SCHED_CRLF_EN
    localparam int TAIL  = 2;
`else
    localparam int TAIL  = 0;
`endif

    logic             sys_clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ack;
    logic             transmit;
    logic [7:0]       tx_byte;
    logic             is_transmitting;
    logic             active;
    logic [N-1:0]     owner;
    logic [CNT_W-1:0] bytes_sent;
    logic             err_stall;

    uart_tx_sched #(.N(N), .STALL_CYCLES(STALL), .CNT_W(CNT_W)) dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ack        (req_ack),
        .transmit       (transmit),
        .tx_byte        (tx_byte),
        .is_transmitting(is_transmitting),
        .active         (active),
        .owner          (owner),
        .bytes_sent     (bytes_sent),
        .err_stall      (err_stall)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Requester byte queues: {last, data}
    logic [8:0] rq_mem [N][QD];
    int         rq_head [N];
    int         rq_tail [N];
    int         ack_cnt [N];

    // Reference model state
    int               start_log [$];
    logic [7:0]       tx_log [$];
    int               n_tx = 0;
    int               ptr_m = 0;
    int               cur_m = -1;
    int               tail_left = 0;
    logic [CNT_W-1:0] exp_bytes = '0;

    // UART model controls
    bit rand_gate = 0;
    bit rand_busy = 0;
    bit uart_dead = 0;
    int busy_len  = 10;
    int busy_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // UART: goes busy for a fixed or random number of cycles after each launch.
    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)
            busy_cnt <= 0;
        else if (transmit && !uart_dead)
            busy_cnt <= rand_busy ? int'($urandom_range(8, 2)) : busy_len;
        else if (busy_cnt > 0)
            busy_cnt <= busy_cnt - 1;
    end
    assign is_transmitting = (busy_cnt != 0);

    task automatic push(input int r, input logic [7:0] d, input logic l);
        rq_mem[r][rq_tail[r] % QD] = {l, d};
        rq_tail[r] = rq_tail[r] + 1;
    endtask

    function automatic bit all_empty();
        bit e;
        e = 1;
        for (int i = 0; i < N; i++) if (rq_head[i] != rq_tail[i]) e = 0;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) rq_head[i] = rq_tail[i];
        ptr_m     = 0;
        cur_m     = -1;
        tail_left = 0;
        exp_bytes = '0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
    endtask

    task automatic drive_reqs();
        logic [8:0] h;
        for (int i = 0; i < N; i++) begin
            if (rq_head[i] != rq_tail[i] && (!rand_gate || $urandom_range(3, 0) != 0)) begin
                h = rq_mem[i][rq_head[i] % QD];
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = h[7:0];
                req_last[i]        = h[8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i]        = 1'($urandom_range(1, 0));
            end
        end
    endtask

    // Frame-level expectation for one observed launch pulse.
    task automatic observe_launch();
        int w;
        int idx;
        logic [8:0] h;
        n_tx++;
        exp_bytes = exp_bytes + CNT_W'(1);
        tx_log.push_back(tx_byte);
        check("no_launch_while_busy", 32'(is_transmitting), 0);
        check("active_at_launch", 32'(active), 1);
        if (tail_left > 0) begin
            check("crlf_byte", 32'(tx_byte), (tail_left == 2) ? 32'h0d : 32'h0a);
            check("crlf_no_ack", 32'(req_ack), 0);
            tail_left--;
            if (tail_left == 0) begin
                ptr_m = (cur_m + 1) % N;
                cur_m = -1;
            end
        end else begin
            if (cur_m < 0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (ptr_m + k) % N;
                    if (w < 0 && req_valid[idx]) w = idx;
                end
                if (w < 0) begin
                    check("arb_had_request", 32'(|req_valid), 1);
                    w = 0;
                end
                cur_m = w;
                start_log.push_back(w);
            end
            check("owner_onehot", 32'(owner), 32'(1) << cur_m);
            check("ack_owner", 32'(req_ack), 32'(1) << cur_m);
            check("pending_byte", 32'(rq_tail[cur_m] != rq_head[cur_m]), 1);
            if (rq_tail[cur_m] != rq_head[cur_m]) begin
                h = rq_mem[cur_m][rq_head[cur_m] % QD];
                rq_head[cur_m] = rq_head[cur_m] + 1;
                ack_cnt[cur_m] = ack_cnt[cur_m] + 1;
                check("tx_byte", 32'(tx_byte), 32'(h[7:0]));
                if (h[8]) begin
                    if (TAIL > 0) begin
                        tail_left = TAIL;
                    end else begin
                        ptr_m = (cur_m + 1) % N;
                        cur_m = -1;
                    end
                end
            end
        end
        check("bytes_sent", 32'(bytes_sent), 32'(exp_bytes));
    endtask

    // Monitor + requester driver, both away from the active edge.
    always @(negedge sys_clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            if (transmit) observe_launch();
            else if (req_ack != '0) check("ack_without_launch", 32'(req_ack), 0);
            drive_reqs();
        end
    end

    task automatic wait_idle(input int budget, input string tag);
        bit done;
        done = 0;
        for (int t = 0; t < budget && !done; t++) begin
            @(negedge sys_clk);
            done = all_empty() && !active && !is_transmitting;
        end
        check(tag, 32'(done), 1);
    endtask

    task automatic wait_busy(input logic level, input string tag);
        int t;
        t = 0;
        while (is_transmitting !== level && t < 200) begin
            @(negedge sys_clk);
            t++;
        end
        check(tag, 32'(is_transmitting), 32'(level));
    endtask

    task automatic wait_tx_count(input int target, input string tag);
        int t;
        t = 0;
        while (n_tx < target && t < 2000) begin
            @(negedge sys_clk);
            t++;
        end
        check(tag, 32'(n_tx >= target), 1);
    endtask

    initial begin
        int exp_rr [5] = '{0, 1, 2, 3, 0};
        int a0;
        int base;
        int k;
        int nf;
        int len;
        logic [CNT_W-1:0] b0;

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < N; i++) begin
            rq_head[i] = 0;
            rq_tail[i] = 0;
            ack_cnt[i] = 0;
        end
        repeat (3) @(negedge sys_clk);
        check("rst_transmit", 32'(transmit), 0);
        check("rst_req_ack", 32'(req_ack), 0);
        check("rst_tx_byte", 32'(tx_byte), 0);
        check("rst_active", 32'(active), 0);
        check("rst_owner", 32'(owner), 0);
        check("rst_bytes_sent", 32'(bytes_sent), 0);
        check("rst_err_stall", 32'(err_stall), 0);
        #2 rst_n = 1'b1;

        // All four requesters hold 1-byte frames: order 0,1,2,3 then 0 again.
        @(negedge sys_clk);
        start_log.delete();
        busy_len = 4;
        push(0, 8'hA0, 1); push(1, 8'hA1, 1); push(2, 8'hA2, 1); push(3, 8'hA3, 1);
        push(0, 8'hB0, 1);
        wait_idle(3000, "rr_idle");
        check("rr_frames", 32'(start_log.size()), 5);
        for (int i = 0; i < 5; i++) check("rr_order", 32'(start_log[i]), 32'(exp_rr[i]));

        // Requester 0 sends 0x41, 0x42(last); UART busy 10 cycles per byte.
        @(negedge sys_clk);
        tx_log.delete();
        busy_len = 10;
        a0   = ack_cnt[0];
        b0   = bytes_sent;
        base = n_tx;
        push(0, 8'h41, 0); push(0, 8'h42, 1);
        wait_tx_count(base + 2 + TAIL, "t1_launches");
        wait_busy(1'b1, "t1_busy_rise");
        wait_busy(1'b0, "t1_busy_fall");
        check("t1_active_before_drop", 32'(active), 1);
        @(negedge sys_clk);
        check("t1_active_dropped", 32'(active), 0);
        wait_idle(500, "t1_idle");
        check("t1_byte0", 32'(tx_log[0]), 32'h41);
        check("t1_byte1", 32'(tx_log[1]), 32'h42);
        check("t1_acks", 32'(ack_cnt[0] - a0), 2);
        check("t1_bytes_sent", 32'(CNT_W'(bytes_sent - b0)), 32'(2 + TAIL));

        // Requester 1 holds a 3-byte frame while requester 2 waits continuously.
        @(negedge sys_clk);
        start_log.delete();
        busy_len = 5;
        push(1, 8'h61, 0); push(1, 8'h62, 0); push(1, 8'h63, 1); push(2, 8'h71, 1);
        wait_idle(2000, "lock_idle");
        check("lock_frames", 32'(start_log.size()), 2);
        check("lock_first", 32'(start_log[0]), 1);
        check("lock_second", 32'(start_log[1]), 2);

        // Randomized frames, gated valids and random UART busy lengths.
        @(negedge sys_clk);
        rand_gate = 1;
        rand_busy = 1;
        for (int r = 0; r < N; r++) begin
            nf = $urandom_range(5, 3);
            for (int f = 0; f < nf; f++) begin
                len = $urandom_range(4, 1);
                for (int b = 0; b < len; b++) push(r, 8'($urandom), 1'(b == len - 1));
            end
        end
        wait_idle(20000, "rand_idle");
        rand_gate = 0;
        rand_busy = 0;
        check("no_stall_in_normal_run", 32'(err_stall), 0);

        // UART never goes busy: stall flagged STALL cycles after the pulse, frame continues.
        @(negedge sys_clk);
        tx_log.delete();
        uart_dead = 1;
        push(3, 8'h11, 0); push(3, 8'h22, 1);
        k = 0;
        while (!transmit && k < 200) begin
            @(negedge sys_clk);
            k++;
        end
        check("stall_launch_seen", 32'(transmit), 1);
        k = 0;
        while (!err_stall && k < 4 * STALL) begin
            @(negedge sys_clk);
            k++;
        end
        check("stall_latency", 32'(k), 32'(STALL));
        wait_idle(2000, "stall_idle");
        check("stall_launches", 32'(tx_log.size()), 32'(2 + TAIL));
        check("stall_next_byte", 32'(tx_log[1]), 32'h22);
        check("stall_sticky", 32'(err_stall), 1);
        uart_dead = 0;

        // Reset during WAIT_DONE of a 4-byte frame; pointer must restart at 0.
        @(negedge sys_clk);
        busy_len = 10;
        push(1, 8'h31, 1);
        wait_idle(500, "pre_rst_idle");
        base = n_tx;
        push(2, 8'h81, 0); push(2, 8'h82, 0); push(2, 8'h83, 0); push(2, 8'h84, 1);
        wait_tx_count(base + 1, "rst_first_launch");
        wait_busy(1'b1, "rst_busy_rise");
        repeat (3) @(negedge sys_clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_transmit", 32'(transmit), 0);
        check("arst_req_ack", 32'(req_ack), 0);
        check("arst_active", 32'(active), 0);
        check("arst_bytes_sent", 32'(bytes_sent), 0);
        check("arst_err_stall", 32'(err_stall), 0);
        check("arst_owner", 32'(owner), 0);
        repeat (2) @(negedge sys_clk);
        #2 rst_n = 1'b1;
        @(negedge sys_clk);
        start_log.delete();
        tx_log.delete();
        push(3, 8'h53, 1); push(0, 8'h50, 1);
        wait_idle(1000, "post_rst_idle");
        check("post_rst_first_owner", 32'(start_log[0]), 0);
        check("post_rst_second_owner", 32'(start_log[1]), 3);
        check("post_rst_first_byte", 32'(tx_log[0]), 32'h50);

`ifdef UART_TX_SCHED_CRLF_EN
        // 1-byte frame 0x55 followed by CR LF.
        @(negedge sys_clk);
        tx_log.delete();
        a0 = ack_cnt[0];
        b0 = bytes_sent;
        push(0, 8'h55, 1);
        wait_idle(1000, "crlf_idle");
        check("crlf_len", 32'(tx_log.size()), 3);
        check("crlf_b0", 32'(tx_log[0]), 32'h55);
        check("crlf_b1", 32'(tx_log[1]), 32'h0d);
        check("crlf_b2", 32'(tx_log[2]), 32'h0a);
        check("crlf_acks", 32'(ack_cnt[0] - a0), 1);
        check("crlf_bytes_sent", 32'(CNT_W'(bytes_sent - b0)), 3);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmitter among N byte-stream requesters.
- Sits between the requester logic (debug echo, status reporter, command responder) and the uart instance's transmit/tx_byte/is_transmitting interface.
- Arbitrates on frame boundaries: once a requester wins, it holds the transmitter until its byte flagged last has been sent.
- Paces each byte against is_transmitting, so no byte is launched while the UART is busy.

Parameters:
- N, 4, number of requesters (2..8).
- STALL_CYCLES, 16, max cycles to wait for is_transmitting to rise after a launch before declaring a stall.
- CNT_W, 16, width of the bytes_sent counter.

Ports:
- sys_clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  N  requester i has a byte ready; held until acked.
- req_data  input  8*N  byte of requester i at [8i+7:8i].
- req_last  input  N  requester i's current byte ends its frame.
- req_ack  output  N  one-cycle pulse: requester i's byte was latched; it may present the next byte.
- transmit  output  1  one-cycle launch pulse to the UART.
- tx_byte  output  8  byte to the UART, stable from launch until the next launch.
- is_transmitting  input  1  UART busy flag.
- active  output  1  a frame is in progress (lock held).
- owner  output  N  one-hot current/last owner.
- bytes_sent  output  CNT_W  count of launched bytes; wraps modulo 2^CNT_W.
- err_stall  output  1  sticky; set when a launch was not acknowledged by is_transmitting.

Behaviour:
- Reset values: all outputs 0, tx_byte 8'h00, round-robin pointer 0, state IDLE. Reset is asynchronous; transmit and req_ack drop immediately. A partially sent frame is abandoned with no further acks.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, HOLD (plus CR, LF with the optional feature).
- IDLE:
  - Wait for is_transmitting=0 and any req_valid.
  - Pick the first set req_valid bit scanning from pointer upward, modulo N.
  - Register the winner in owner, set active=1, go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - Assert transmit=1 and req_ack[owner]=1.
  - Load tx_byte from req_data[owner] and capture req_last[owner].
  - Increment bytes_sent, go to WAIT_BUSY.
  - Latency: transmit is asserted in the cycle after IDLE samples req_valid.
- WAIT_BUSY:
  - On is_transmitting=1, go to WAIT_DONE.
  - If STALL_CYCLES cycles elapse without it, set err_stall=1 and treat the byte as sent (continue as on WAIT_DONE exit).
- WAIT_DONE:
  - On is_transmitting=0: if the captured last was 1, end the frame; else go to HOLD.
- HOLD:
  - Wait for req_valid[owner]; on it, go to LAUNCH.
  - Other requesters are ignored, even if the owner stalls indefinitely.
- End of frame:
  - active=0, pointer <= owner index + 1 (mod N), state IDLE. owner keeps its last value.
- Boundary cases:
  - Simultaneous requests resolve by pointer order only.
  - A requester dropping req_valid before its ack is legal and loses nothing.
  - req_last on a single byte gives a 1-byte frame.
  - bytes_sent wraps 0xFFFF -> 0x0000 silently.
  - err_stall clears only on reset.

Optional Feature:
- Macro: UART_TX_SCHED_CRLF_EN.
- Defined: after WAIT_DONE of a last byte, the FSM launches 8'h0d (state CR) then 8'h0a (state LF). Each uses the same LAUNCH/WAIT_BUSY/WAIT_DONE pacing but with no req_ack, and each counts in bytes_sent. The lock and active stay held until LF completes.
- Not defined: the frame ends directly after the last byte; CR and LF states are absent.

Test Plan:
- Single requester 0 sends frame 8'h41, 8'h42 (last); UART model busy 10 cycles per byte -> transmit pulses carry 0x41 then 0x42, exactly two req_ack[0] pulses, bytes_sent=2, active falls after the second byte's busy drops.
- req_valid=4'b1111 each with a 1-byte frame, all held -> launch order owner 0,1,2,3, then 0 again; never two launches while is_transmitting=1.
- Requester 1 mid-frame (3 bytes) while requester 2 asserts continuously -> requester 2's byte launches only after requester 1's last byte completes; owner=4'b0010 throughout the frame.
- UART model never raises is_transmitting -> err_stall=1 exactly STALL_CYCLES cycles after the transmit pulse; FSM proceeds and the next byte launches.
- Assert rst_n=0 during WAIT_DONE of a 4-byte frame -> transmit, req_ack, active, bytes_sent, err_stall all 0 in the same cycle; after release, the pointer restarts at requester 0.
- With UART_TX_SCHED_CRLF_EN, a 1-byte frame 8'h55 -> transmitted sequence 0x55, 0x0d, 0x0a; one req_ack; bytes_sent=3.
